// File: rtl/lif_step_scheduler_if.sv
// LIF step scheduler bus: controller side (master) and neuron block side (slave).
// Groups step control, current fetch, status and debug potential read.
interface lif_step_scheduler_if #(
  parameter int N_NEURONS = 8,
  parameter int IDX_W     = $clog2(N_NEURONS)
);
  logic                 start;
  logic                 clear;
  logic [3:0]           beta;
  logic [7:0]           threshold;
  logic [IDX_W-1:0]     cur_idx;
  logic [7:0]           cur_in;
  logic                 busy;
  logic                 done;
  logic [N_NEURONS-1:0] spikes;
  logic                 cfg_err;
  logic [IDX_W-1:0]     pot_rd_idx;
  logic [7:0]           pot_rd_data;

  modport master (
    output start, clear, beta, threshold,
    output cur_in, pot_rd_idx,
    input  cur_idx, busy, done, spikes,
    input  cfg_err, pot_rd_data
  );

  modport slave (
    input  start, clear, beta, threshold,
    input  cur_in, pot_rd_idx,
    output cur_idx, busy, done, spikes,
    output cfg_err, pot_rd_data
  );
endinterface

// File: rtl/lif_step_scheduler.sv
// Sweeps N leaky integrate-and-fire neurons through one shared
// shift-add decay multiplier; owns the membrane potential storage.
module lif_step_scheduler #(
  parameter int N_NEURONS = 8,
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input logic clk,
  input logic rst,
  lif_step_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECAY,
    S_INTEG,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [7:0]           r_pot [N_NEURONS];
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     r_cur_idx;
  logic [3:0]           r_beta;
  logic [7:0]           r_thr;
  logic [7:0]           r_dec;
  logic [N_NEURONS-1:0] r_spikes;
  logic                 r_cfg_err;
  logic [8:0]           w_sum;
  logic [7:0]           w_sat;
  logic                 w_last;
  logic                 w_busy;
  logic                 w_done;

  // Truncating shift-add: each term is truncated before summing.
  function automatic logic [7:0] f_mult(
    input logic [7:0] p,
    input logic [3:0] b
  );
    logic [7:0] r;
    r = '0;
    case (b)
      4'd1:    r = p >> 3;
      4'd2:    r = p >> 2;
      4'd3:    r = (p >> 2) + (p >> 3);
      4'd4:    r = p >> 1;
      4'd5:    r = (p >> 1) + (p >> 3);
      4'd6:    r = (p >> 1) + (p >> 2);
      4'd7:    r = (p >> 1) + (p >> 2) + (p >> 3);
      4'd8:    r = p;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign w_sum  = {1'b0, r_dec} + {1'b0, bus.cur_in};
  assign w_sat  = w_sum[8] ? 8'hFF : w_sum[7:0];
  assign w_last = (r_idx == IDX_W'(N_NEURONS - 1));

  assign bus.cur_idx     = r_cur_idx;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.spikes      = r_spikes;
  assign bus.cfg_err     = r_cfg_err;
  assign bus.pot_rd_data = r_pot[bus.pot_rd_idx];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and status outputs.
  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (!bus.clear && bus.start) w_next = S_DECAY;
      end
      S_DECAY: w_next = S_INTEG;
      S_INTEG: w_next = w_last ? S_DONE : S_DECAY;
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: config latch, decay, integrate/fire, potential store.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) r_pot[i] <= '0;
      r_idx     <= '0;
      r_cur_idx <= '0;
      r_beta    <= '0;
      r_thr     <= '0;
      r_dec     <= '0;
      r_spikes  <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.clear) begin
            for (int i = 0; i < N_NEURONS; i++) r_pot[i] <= '0;
          end else if (bus.start) begin
            r_thr     <= bus.threshold;
            r_beta    <= (bus.beta > 4'd8) ? 4'd8 : bus.beta;
            r_cfg_err <= (bus.beta > 4'd8);
            r_spikes  <= '0;
            r_idx     <= '0;
          end
        end
        S_DECAY: begin
          r_dec     <= f_mult(r_pot[r_idx], r_beta);
          r_cur_idx <= r_idx;
        end
        S_INTEG: begin
          if (w_sat >= r_thr) begin
            r_spikes[r_idx] <= 1'b1;
            r_pot[r_idx]    <= '0;
          end else begin
            r_pot[r_idx] <= w_sat;
          end
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        S_DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Self-checking bench for lif_step_scheduler with N=4 and a
// behavioural LIF model (arithmetic on integers, not RTL mirroring).
module tb_lif_step_scheduler;

  localparam int N = 4;

  logic clk;
  logic rst;

  lif_step_scheduler_if #(.N_NEURONS(N)) bus ();

  lif_step_scheduler #(.N_NEURONS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_pass;
  int         n_total;
  int         mpot [N];
  logic [7:0] cur_tab [N];
  logic [N-1:0] exp_spikes;
  logic       exp_cfg;

  // Decay by b/8 with each power-of-two term truncated on its own.
  function automatic int model_decay(input int p, input int b);
    int r;
    if (b >= 8) return p;
    r = 0;
    if ((b & 4) != 0) r += p / 2;
    if ((b & 2) != 0) r += p / 4;
    if ((b & 1) != 0) r += p / 8;
    return r;
  endfunction

  function automatic void model_sweep(input int b, input int th);
    int beff;
    int s;
    beff       = (b > 8) ? 8 : b;
    exp_cfg    = (b > 8);
    exp_spikes = '0;
    for (int k = 0; k < N; k++) begin
      s = model_decay(mpot[k], beff) + int'(cur_tab[k]);
      if (s > 255) s = 255;
      if (s >= th) begin
        exp_spikes[k] = 1'b1;
        mpot[k] = 0;
      end else begin
        mpot[k] = s;
      end
    end
  endfunction

  // One full sweep; checks busy/done/cur_idx timing along the way.
  task automatic run_sweep(input int b, input int th, input bit inject);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.beta      = 4'(b);
    bus.threshold = 8'(th);
    @(negedge clk);
    bus.start = 1'b0;
    model_sweep(b, th);
    for (int k = 0; k < N; k++) begin
      bus.cur_in = cur_tab[k];
      n_total++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0)
        $display("FAIL decay_status n%0d busy=%b done=%b want 1/0",
                 k, bus.busy, bus.done);
      else n_pass++;
      if (inject && k == 1) begin
        bus.start     = 1'b1;
        bus.clear     = 1'b1;
        bus.beta      = 4'($urandom_range(0, 15));
        bus.threshold = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.clear = 1'b0;
      n_total++;
      if (bus.cur_idx !== 2'(k) || bus.done !== 1'b0)
        $display("FAIL integ_cur_idx got=%0d done=%b want %0d/0",
                 bus.cur_idx, bus.done, k);
      else n_pass++;
      @(negedge clk);
    end
    n_total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1)
      $display("FAIL done_pulse done=%b busy=%b want 1/1",
               bus.done, bus.busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL after_done done=%b busy=%b want 0/0",
               bus.done, bus.busy);
    else n_pass++;
  endtask

  task automatic set_cur(input int c);
    for (int k = 0; k < N; k++) cur_tab[k] = 8'(c);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N; k++) mpot[k] = 0;
    exp_spikes = '0;
    exp_cfg    = 1'b0;
    n_total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.spikes !== 4'h0 || bus.cfg_err !== 1'b0 ||
        bus.cur_idx !== 2'd0)
      $display("FAIL reset busy=%b done=%b sp=%h cfg=%b ci=%0d want 0",
               bus.busy, bus.done, bus.spikes, bus.cfg_err, bus.cur_idx);
    else n_pass++;
    for (int k = 0; k < N; k++) begin
      bus.pot_rd_idx = 2'(k);
      #1;
      n_total++;
      if (bus.pot_rd_data !== 8'd0)
        $display("FAIL reset_pot n%0d got=%0d want 0", k, bus.pot_rd_data);
      else n_pass++;
    end
  endtask

  task automatic test_basic;
    int exp_p [3];
    logic [3:0] exp_s [3];
    exp_p = '{60, 90, 0};
    exp_s = '{4'h0, 4'h0, 4'hF};
    set_cur(60);
    for (int s = 0; s < 3; s++) begin
      run_sweep(4, 100, 1'b0);
      n_total++;
      if (bus.spikes !== exp_s[s])
        $display("FAIL basic_spikes s%0d got=%h want %h",
                 s, bus.spikes, exp_s[s]);
      else n_pass++;
      for (int k = 0; k < N; k++) begin
        bus.pot_rd_idx = 2'(k);
        #1;
        n_total++;
        if (bus.pot_rd_data !== 8'(exp_p[s]))
          $display("FAIL basic_pot s%0d n%0d got=%0d want %0d",
                   s, k, bus.pot_rd_data, exp_p[s]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_truncation;
    int bt [3];
    int cr [3];
    int ex [3];
    bt = '{8, 7, 3};
    cr = '{200, 0, 0};
    ex = '{200, 175, 64};
    for (int s = 0; s < 3; s++) begin
      set_cur(cr[s]);
      run_sweep(bt[s], 255, 1'b0);
      bus.pot_rd_idx = 2'(s + 1);
      #1;
      n_total++;
      if (bus.pot_rd_data !== 8'(ex[s]) || bus.spikes !== 4'h0)
        $display("FAIL trunc s%0d pot=%0d sp=%h want %0d/0",
                 s, bus.pot_rd_data, bus.spikes, ex[s]);
      else n_pass++;
    end
  endtask

  task automatic test_saturation;
    set_cur(200);
    run_sweep(0, 255, 1'b0);
    set_cur(100);
    run_sweep(8, 255, 1'b0);
    bus.pot_rd_idx = 2'd2;
    #1;
    n_total++;
    if (bus.spikes !== 4'hF || bus.pot_rd_data !== 8'd0)
      $display("FAIL sat_clamp sp=%h pot=%0d want f/0",
               bus.spikes, bus.pot_rd_data);
    else n_pass++;
    set_cur(0);
    run_sweep(0, 0, 1'b0);
    n_total++;
    if (bus.spikes !== 4'hF)
      $display("FAIL thr_zero sp=%h want f", bus.spikes);
    else n_pass++;
  endtask

  task automatic test_cfg_err;
    set_cur(40);
    run_sweep(0, 255, 1'b0);
    set_cur(0);
    run_sweep(9, 255, 1'b0);
    bus.pot_rd_idx = 2'd3;
    #1;
    n_total++;
    if (bus.cfg_err !== 1'b1 || bus.pot_rd_data !== 8'd40)
      $display("FAIL cfg_err_set cfg=%b pot=%0d want 1/40",
               bus.cfg_err, bus.pot_rd_data);
    else n_pass++;
    run_sweep(2, 255, 1'b0);
    #1;
    n_total++;
    if (bus.cfg_err !== 1'b0 || bus.pot_rd_data !== 8'd10)
      $display("FAIL cfg_err_clr cfg=%b pot=%0d want 0/10",
               bus.cfg_err, bus.pot_rd_data);
    else n_pass++;
  endtask

  task automatic test_busy_ignore;
    for (int k = 0; k < N; k++) cur_tab[k] = 8'(30 + 20 * k);
    run_sweep(5, 90, 1'b1);
    repeat (3) begin
      @(negedge clk);
      n_total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0)
        $display("FAIL ignore_extra busy=%b done=%b want 0/0",
                 bus.busy, bus.done);
      else n_pass++;
    end
    n_total++;
    if (bus.spikes !== exp_spikes || bus.cfg_err !== exp_cfg)
      $display("FAIL ignore_spikes sp=%h cfg=%b want %h/%b",
               bus.spikes, bus.cfg_err, exp_spikes, exp_cfg);
    else n_pass++;
    for (int k = 0; k < N; k++) begin
      bus.pot_rd_idx = 2'(k);
      #1;
      n_total++;
      if (int'(bus.pot_rd_data) !== mpot[k])
        $display("FAIL ignore_pot n%0d got=%0d want %0d",
                 k, bus.pot_rd_data, mpot[k]);
      else n_pass++;
    end
  endtask

  task automatic test_clear_start;
    @(negedge clk);
    bus.clear = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.start = 1'b0;
    for (int k = 0; k < N; k++) mpot[k] = 0;
    repeat (3) begin
      n_total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0)
        $display("FAIL clear_busy busy=%b done=%b want 0/0",
                 bus.busy, bus.done);
      else n_pass++;
      @(negedge clk);
    end
    n_total++;
    if (bus.spikes !== exp_spikes)
      $display("FAIL clear_spikes sp=%h want %h", bus.spikes, exp_spikes);
    else n_pass++;
    for (int k = 0; k < N; k++) begin
      bus.pot_rd_idx = 2'(k);
      #1;
      n_total++;
      if (bus.pot_rd_data !== 8'd0)
        $display("FAIL clear_pot n%0d got=%0d want 0", k, bus.pot_rd_data);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    int b;
    int th;
    for (int s = 0; s < 15; s++) begin
      b  = $urandom_range(0, 15);
      th = $urandom_range(20, 255);
      for (int k = 0; k < N; k++) cur_tab[k] = 8'($urandom_range(0, 150));
      run_sweep(b, th, 1'(s % 4 == 3));
      n_total++;
      if (bus.spikes !== exp_spikes || bus.cfg_err !== exp_cfg)
        $display("FAIL rnd_status s%0d sp=%h cfg=%b want %h/%b",
                 s, bus.spikes, bus.cfg_err, exp_spikes, exp_cfg);
      else n_pass++;
      for (int k = 0; k < N; k++) begin
        bus.pot_rd_idx = 2'(k);
        #1;
        n_total++;
        if (int'(bus.pot_rd_data) !== mpot[k])
          $display("FAIL rnd_pot s%0d n%0d got=%0d want %0d",
                   s, k, bus.pot_rd_data, mpot[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid;
    set_cur(70);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.beta      = 4'd6;
    bus.threshold = 8'd250;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    n_total++;
    if (bus.cur_idx !== 2'd2 || bus.busy !== 1'b1)
      $display("FAIL mid_position ci=%0d busy=%b want 2/1",
               bus.cur_idx, bus.busy);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N; k++) mpot[k] = 0;
    n_total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.spikes !== 4'h0 || bus.cfg_err !== 1'b0)
      $display("FAIL mid_reset busy=%b done=%b sp=%h cfg=%b want 0",
               bus.busy, bus.done, bus.spikes, bus.cfg_err);
    else n_pass++;
    for (int k = 0; k < N; k++) begin
      bus.pot_rd_idx = 2'(k);
      #1;
      n_total++;
      if (bus.pot_rd_data !== 8'd0)
        $display("FAIL mid_pot n%0d got=%0d want 0", k, bus.pot_rd_data);
      else n_pass++;
    end
    repeat (2 * N + 2) begin
      @(negedge clk);
      n_total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0)
        $display("FAIL mid_no_done done=%b busy=%b want 0/0",
                 bus.done, bus.busy);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.clear      = 1'b0;
    bus.beta       = 4'd0;
    bus.threshold  = 8'd0;
    bus.cur_in     = 8'd0;
    bus.pot_rd_idx = 2'd0;
    test_reset();
    test_basic();
    test_truncation();
    test_saturation();
    test_cfg_err();
    test_busy_ignore();
    test_clear_start();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
